// File: rtl/disp_sched_if.sv
// Display scheduler bus: mode select, the two display sources and the
// time-shared display/unit-select outputs.
interface disp_sched_if;
  logic [1:0] mode;
  logic [7:0] time_an_n;
  logic [6:0] time_segs_n;
  logic       time_dp_n;
  logic [7:0] temp_an_n;
  logic [6:0] temp_segs_n;
  logic       temp_dp_n;
  logic       cf;
  logic [7:0] an_n;
  logic [6:0] segs_n;
  logic       dp_n;
  logic       src;
  logic [2:0] slot;

  modport master (
    output mode, time_an_n, time_segs_n, time_dp_n,
           temp_an_n, temp_segs_n, temp_dp_n,
    input  cf, an_n, segs_n, dp_n, src, slot
  );

  modport slave (
    input  mode, time_an_n, time_segs_n, time_dp_n,
           temp_an_n, temp_segs_n, temp_dp_n,
    output cf, an_n, segs_n, dp_n, src, slot
  );
endinterface

// File: rtl/disp_sched.sv
// Time-shares one 8-digit seven-segment display between the clock and
// temperature sources on a 6-slot rotation, blanking on every source/unit change.
module disp_sched #(
  parameter int CLKS_PER_SLOT = 200_000_000,
  parameter int BLANK_CLKS    = 100_000
) (
  input  logic         clk,
  input  logic         rst,
  disp_sched_if.slave  bus
);

  localparam int PW = (CLKS_PER_SLOT > 2) ? $clog2(CLKS_PER_SLOT) : 1;
  localparam int BW = (BLANK_CLKS > 0) ? $clog2(BLANK_CLKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SLOT - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CLKS);
  localparam logic [2:0]    SLOT_LAST  = 3'd5;

  // Returns {src, cf} for a slot under a given mode.
  function automatic logic [1:0] slot_map(input logic [1:0] mode, input logic [2:0] slot);
    logic [1:0] r;
    case (mode)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b10;
      2'b10:   r = {slot[0], 1'b0};
      2'b11: begin
        case (slot)
          3'd1, 3'd4: r = 2'b10;
          3'd2, 3'd5: r = 2'b11;
          default:    r = 2'b00;
        endcase
      end
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic [1:0]    sync1_q, sync2_q, mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  logic          src_q, src_d, cf_q, cf_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    segs_q, segs_d;
  logic          dp_q, dp_d;
  logic          upd_s;
  logic [1:0]    map_s;

  // Next-state: mode detect beats terminal count; blank reloads on src/cf change.
  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q + PW'(1);
    slot_d  = slot_q;
    upd_s   = 1'b0;
    if (sync2_q != mode_q) begin
      mode_d  = sync2_q;
      presc_d = '0;
      slot_d  = 3'd0;
      upd_s   = 1'b1;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      slot_d  = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
      upd_s   = 1'b1;
    end else begin
      upd_s   = 1'b0;
    end

    map_s = slot_map(mode_d, slot_d);
    if (upd_s) begin
      src_d = map_s[1];
      cf_d  = map_s[0];
    end else begin
      src_d = src_q;
      cf_d  = cf_q;
    end

    if (upd_s && ((src_d != src_q) || (cf_d != cf_q))) begin
      blank_d = BLANK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BW'(1);
    end else begin
      blank_d = blank_q;
    end

    if (blank_q != '0) begin
      an_d   = 8'hFF;
      segs_d = 7'h7F;
      dp_d   = 1'b1;
    end else if (src_q) begin
      an_d   = bus.temp_an_n;
      segs_d = bus.temp_segs_n;
      dp_d   = bus.temp_dp_n;
    end else begin
      an_d   = bus.time_an_n;
      segs_d = bus.time_segs_n;
      dp_d   = bus.time_dp_n;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      mode_q  <= 2'b00;
      presc_q <= '0;
      slot_q  <= 3'd0;
      src_q   <= 1'b0;
      cf_q    <= 1'b0;
      blank_q <= '0;
      an_q    <= 8'hFF;
      segs_q  <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      sync1_q <= bus.mode;
      sync2_q <= sync1_q;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
      src_q   <= src_d;
      cf_q    <= cf_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      segs_q  <= segs_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.cf     = cf_q;
  assign bus.an_n   = an_q;
  assign bus.segs_n = segs_q;
  assign bus.dp_n   = dp_q;
  assign bus.src    = src_q;
  assign bus.slot   = slot_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched: a per-edge reference model pushes expected
// outputs into a scoreboard queue that is popped after each clock edge.
module tb_disp_sched;
  localparam int CPS = 4;
  localparam int BLK = 2;

  logic clk = 1'b0;
  logic rst;
  disp_sched_if bus();

  disp_sched #(.CLKS_PER_SLOT(CPS), .BLANK_CLKS(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] segs;
    logic       dp;
    logic       src;
    logic [2:0] slot;
    logic       cf;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic [1:0] m_p1, m_p2, m_mode;
  int         m_k;
  logic [2:0] m_slot;
  logic       m_src, m_cf, m_ld1, m_ld2;

  function automatic obs_t reset_obs();
    obs_t o;
    o.an = 8'hFF; o.segs = 7'h7F; o.dp = 1'b1;
    o.src = 1'b0; o.slot = 3'd0; o.cf = 1'b0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.an = bus.an_n; o.segs = bus.segs_n; o.dp = bus.dp_n;
    o.src = bus.src; o.slot = bus.slot; o.cf = bus.cf;
    return o;
  endfunction

  // {src, cf} from the slot table
  function automatic logic [1:0] ref_map(input logic [1:0] md, input logic [2:0] sl);
    int ph;
    ph = int'(sl) % 3;
    if (md == 2'b00) return 2'b00;
    if (md == 2'b01) return 2'b10;
    if (md == 2'b10) return {sl[0], 1'b0};
    if (ph == 0) return 2'b00;
    if (ph == 1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_reset();
    m_p1 = 2'b00; m_p2 = 2'b00; m_mode = 2'b00; m_k = 0;
    m_slot = 3'd0; m_src = 1'b0; m_cf = 1'b0; m_ld1 = 1'b0; m_ld2 = 1'b0;
  endtask

  // Advance the model by one edge and return the outputs expected after it.
  // Output is blank iff a src/cf change happened one or two edges earlier.
  task automatic model_edge(output obs_t e);
    logic       blank, upd;
    logic [1:0] nm;
    if (rst) begin
      model_reset();
      e = reset_obs();
      return;
    end
    blank = m_ld1 || m_ld2;
    if (blank) begin
      e.an = 8'hFF; e.segs = 7'h7F; e.dp = 1'b1;
    end else if (m_src) begin
      e.an = bus.temp_an_n; e.segs = bus.temp_segs_n; e.dp = bus.temp_dp_n;
    end else begin
      e.an = bus.time_an_n; e.segs = bus.time_segs_n; e.dp = bus.time_dp_n;
    end
    upd = 1'b0;
    if (m_p2 != m_mode) begin
      m_mode = m_p2; m_k = 0; m_slot = 3'd0; upd = 1'b1;
    end else begin
      m_k = m_k + 1;
      if (m_k == CPS) begin
        m_k = 0;
        m_slot = (m_slot == 3'd5) ? 3'd0 : m_slot + 3'd1;
        upd = 1'b1;
      end
    end
    m_ld2 = m_ld1;
    m_ld1 = 1'b0;
    if (upd) begin
      nm = ref_map(m_mode, m_slot);
      m_ld1 = (nm[1] != m_src) || (nm[0] != m_cf);
      m_src = nm[1];
      m_cf  = nm[0];
    end
    m_p2 = m_p1;
    m_p1 = bus.mode;
    e.src = m_src; e.slot = m_slot; e.cf = m_cf;
  endtask

  task automatic check(input string tag);
    obs_t e, a;
    e = sb.pop_front();
    a = dut_obs();
    n_tests++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed an=%h segs=%h dp=%b src=%b slot=%0d cf=%b expected an=%h segs=%h dp=%b src=%b slot=%0d cf=%b",
             tag, a.an, a.segs, a.dp, a.src, a.slot, a.cf, e.an, e.segs, e.dp, e.src, e.slot, e.cf);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic randomize_srcs();
    bus.time_an_n   = 8'($urandom) & 8'hFE;
    bus.time_segs_n = 7'($urandom);
    bus.time_dp_n   = 1'($urandom);
    bus.temp_an_n   = 8'($urandom) & 8'hFD;
    bus.temp_segs_n = 7'($urandom);
    bus.temp_dp_n   = 1'($urandom);
  endtask

  task automatic tick(input string tag);
    obs_t e;
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
    randomize_srcs();
  endtask

  // Raise rst between edges and check the outputs drop without a clock.
  task automatic async_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    sb.push_back(reset_obs());
    check(tag);
    model_reset();
    tick("rst_hold");
    rst = 1'b0;
  endtask

  function automatic logic is_blank();
    return (bus.an_n === 8'hFF) && (bus.segs_n === 7'h7F) && (bus.dp_n === 1'b1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blanks;
    rst = 1'b1;
    bus.mode = 2'b00;
    randomize_srcs();
    bus.time_segs_n = 7'h12;
    model_reset();
    tick("reset");
    bus.time_segs_n = 7'h12;
    tick("reset");
    rst = 1'b0;
    bus.time_segs_n = 7'h12;
    tick("passthru_first");
    check_val("passthru_segs", 32'(bus.segs_n), 32'h12);
    for (int i = 0; i < 13; i++) tick("mode00");

    async_reset("async_rst_midrun");
    for (int i = 0; i < 5; i++) tick("mode00_after_rst");

    // mode 10 rotation with blanking at every boundary
    bus.mode = 2'b10;
    for (int i = 0; i < 3; i++) tick("m10_sync");
    check_val("m10_detect_slot", 32'(bus.slot), 32'd0);
    for (int i = 0; i < 4; i++) tick("m10");
    blanks = 0;
    for (int i = 0; i < 24; i++) begin
      tick("m10_rot");
      if (is_blank()) blanks++;
    end
    check_val("m10_blank_cycles", 32'(blanks), 32'd12);

    // mode change mid-slot at slot 3
    for (int i = 0; i < 40 && !(m_slot == 3'd3 && m_k == 0); i++) tick("m10_wait");
    bus.mode = 2'b11;
    for (int i = 0; i < 3; i++) tick("m11_sync");
    check_val("m11_change_slot", 32'(bus.slot), 32'd0);
    for (int i = 0; i < 3; i++) tick("m11_presc");
    check_val("m11_hold_slot", 32'(bus.slot), 32'd0);
    tick("m11_adv");
    check_val("m11_adv_slot", 32'(bus.slot), 32'd1);
    for (int i = 0; i < 26; i++) tick("m11_rot");

    // mode change landing on the terminal count of slot 4
    for (int i = 0; i < 40 && !(m_slot == 3'd4 && m_k == 1); i++) tick("m11_wait");
    bus.mode = 2'b10;
    for (int i = 0; i < 3; i++) tick("simul_sync");
    check_val("simul_slot", 32'(bus.slot), 32'd0);
    blanks = 0;
    for (int i = 0; i < 3; i++) begin
      tick("simul_after");
      if (is_blank()) blanks++;
    end
    check_val("simul_blank_cycles", 32'(blanks), 32'd2);

    // reset in the middle of a blank window
    for (int i = 0; i < 20 && !m_ld1; i++) tick("m10_wait_load");
    tick("m10_midblank");
    async_reset("async_rst_midblank");
    for (int i = 0; i < 12; i++) tick("after_rst_m10_pin");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
